// File: rtl/phys_freelist_ctrl.sv
// phys_freelist_ctrl: physical-register free bitmap for R10K rename. It grants up to N PRs
// per cycle and rebuilds the bitmap from the arch map on recovery. Optional macro: FREELIST_DOUBLE_FREE_CHECK_EN.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module phys_freelist_ctrl #(
  parameter int N          = `N,
  parameter int ARCH_COUNT = 32,
  parameter int PHYS_REGS  = `PHYS_REG_SZ_R10K,
  parameter int SCAN_W     = 4,
  localparam int PRW = $clog2(PHYS_REGS),
  localparam int RIW = $clog2(ARCH_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          alloc_req,
  output logic [N-1:0]          alloc_gnt,
  output logic [N*PRW-1:0]      alloc_tags,
  input  logic [PHYS_REGS-1:0]  free_mask,
  input  logic                  recover_en,
  output logic [SCAN_W*RIW-1:0] arch_rd_idx,
  input  logic [SCAN_W*PRW-1:0] arch_rd_tag,
  output logic                  busy,
  output logic [PRW:0]          free_count,
  output logic                  double_free_err
);

  localparam int CW          = PRW + 1;
  localparam int SCAN_CYCLES = ARCH_COUNT / SCAN_W;
  localparam int KW          = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [PHYS_REGS-1:0] RESET_MAP   = {PHYS_REGS{1'b1}} << ARCH_COUNT;
  localparam logic [PHYS_REGS-1:0] SHADOW_INIT = {{(PHYS_REGS-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, REBUILD} state_t;

  state_t               state, state_next;
  logic [PHYS_REGS-1:0] bitmap, bitmap_next;
  logic [PHYS_REGS-1:0] shadow, shadow_next;
  logic [PHYS_REGS-1:0] grant_mask, avail, free_clean;
  logic [KW-1:0]        scan_k;
  logic [CW-1:0]        free_count_next;
  logic [PRW-1:0]       rd_tag;
  logic                 alloc_en, scan_done, refused, found;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A recovery pulse always wins: it suppresses this cycle's grants and (re)starts the scan.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    alloc_en   = 1'b0;
    scan_done  = 1'b0;
    case (state)
      IDLE: begin
        alloc_en = !recover_en && !reset;
        if (recover_en) state_next = REBUILD;
      end
      REBUILD: begin
        busy = 1'b1;
        if (!recover_en && scan_k == KW'(SCAN_CYCLES - 1)) begin
          scan_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Oldest lane first; the first refused requester blocks every younger lane.
  always_comb begin
    alloc_gnt  = '0;
    alloc_tags = '0;
    grant_mask = '0;
    avail      = bitmap;
    avail[0]   = 1'b0;
    refused    = 1'b0;
    found      = 1'b0;
    for (int w = N - 1; w >= 0; w--) begin
      if (alloc_en && alloc_req[w] && !refused) begin
        found = 1'b0;
        for (int p = 1; p < PHYS_REGS; p++) begin
          if (avail[p] && !found) begin
            found                       = 1'b1;
            avail[p]                    = 1'b0;
            grant_mask[p]               = 1'b1;
            alloc_tags[w*PRW +: PRW]    = PRW'(p);
          end
        end
        if (found) alloc_gnt[w] = 1'b1;
        else       refused      = 1'b1;
      end
    end
  end

  always_comb begin
    shadow_next = shadow;
    arch_rd_idx = '0;
    rd_tag      = '0;
    if (busy) begin
      for (int j = 0; j < SCAN_W; j++) begin
        arch_rd_idx[j*RIW +: RIW] = RIW'(int'(scan_k) * SCAN_W + j);
        rd_tag = arch_rd_tag[j*PRW +: PRW];
        if (int'(rd_tag) < PHYS_REGS) shadow_next[rd_tag] = 1'b0;
      end
    end
  end

  // Frees are applied after grants so a same-cycle grant+free leaves the PR free.
  always_comb begin
    free_clean    = free_mask;
    free_clean[0] = 1'b0;
    bitmap_next   = bitmap;
    if (state == IDLE)  bitmap_next = (bitmap & ~grant_mask) | free_clean;
    else if (scan_done) bitmap_next = shadow_next;
    bitmap_next[0] = 1'b0;
    free_count_next = '0;
    for (int p = 0; p < PHYS_REGS; p++) begin
      free_count_next = free_count_next + CW'(bitmap_next[p]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitmap     <= RESET_MAP;
      free_count <= CW'(PHYS_REGS - ARCH_COUNT);
      shadow     <= '0;
      scan_k     <= '0;
    end else begin
      bitmap     <= bitmap_next;
      free_count <= free_count_next;
      if (recover_en) begin
        shadow <= SHADOW_INIT;
        scan_k <= '0;
      end else if (state == REBUILD) begin
        shadow <= shadow_next;
        scan_k <= scan_k + KW'(1);
      end
    end
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  logic dbl_hit;
  assign dbl_hit = (state == IDLE) && (|(free_clean & (bitmap | grant_mask)));

  always_ff @(posedge clock) begin
    if (reset) begin
      double_free_err <= 1'b0;
    end else if (dbl_hit) begin
      double_free_err <= 1'b1;
      $error("phys_freelist_ctrl: double free, mask=%h", free_clean & (bitmap | grant_mask));
    end
  end
`else
  assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_freelist_ctrl.sv
// Scoreboard bench for phys_freelist_ctrl (N=2, 64 PRs, 32 arch regs, SCAN_W=4).
module tb_phys_freelist_ctrl;
  localparam int N = 2, PHYS_REGS = 64, ARCH_COUNT = 32, SCAN_W = 4, PRW = 6, RIW = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0]          alloc_req;
  logic [N-1:0]          alloc_gnt;
  logic [N*PRW-1:0]      alloc_tags;
  logic [PHYS_REGS-1:0]  free_mask;
  logic                  recover_en;
  logic [SCAN_W*RIW-1:0] arch_rd_idx;
  logic [SCAN_W*PRW-1:0] arch_rd_tag;
  logic                  busy;
  logic [PRW:0]          free_count;
  logic                  double_free_err;

  phys_freelist_ctrl dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tags(alloc_tags), .free_mask(free_mask), .recover_en(recover_en),
    .arch_rd_idx(arch_rd_idx), .arch_rd_tag(arch_rd_tag), .busy(busy),
    .free_count(free_count), .double_free_err(double_free_err)
  );

  always #5 clock = ~clock;

  logic [PRW-1:0] arch_map [ARCH_COUNT];

  always_comb begin
    arch_rd_tag = '0;
    for (int j = 0; j < SCAN_W; j++)
      arch_rd_tag[j*PRW +: PRW] = arch_map[arch_rd_idx[j*RIW +: RIW]];
  end

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [N*PRW-1:0] tags;
    logic [PRW:0]     fc;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 e;
  logic [PHYS_REGS-1:0] model_map;
  int                   checks = 0;
  int                   errors = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Predicts this cycle's grants from the reference bitmap, then drives the inputs.
  task automatic drive(input logic [N-1:0] req, input logic [PHYS_REGS-1:0] fm);
    exp_t ex;
    logic [PHYS_REGS-1:0] av, taken;
    bit refusedf;
    int lo;
    ex = '0;
    av = model_map;
    av[0] = 1'b0;
    taken = '0;
    refusedf = 1'b0;
    ex.fc = (PRW+1)'($countones(model_map));
    for (int w = N - 1; w >= 0; w--) begin
      if (req[w] && !refusedf) begin
        lo = -1;
        for (int p = PHYS_REGS - 1; p >= 1; p--) if (av[p]) lo = p;
        if (lo < 0) refusedf = 1'b1;
        else begin
          ex.gnt[w] = 1'b1;
          ex.tags[w*PRW +: PRW] = PRW'(lo);
          av[lo] = 1'b0;
          taken[lo] = 1'b1;
        end
      end
    end
    model_map = (model_map & ~taken) | fm;
    model_map[0] = 1'b0;
    exp_q.push_back(ex);
    alloc_req = req;
    free_mask = fm;
  endtask

  task automatic test_reset;
    reset = 1'b1; alloc_req = 2'b11; free_mask = '0; recover_en = 1'b0;
    for (int i = 0; i < ARCH_COUNT; i++) arch_map[i] = PRW'(i);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (alloc_gnt !== 2'b00 || alloc_tags !== '0) begin
      errors++; $display("[TB] FAIL reset_gnt: got gnt=%b tags=%h, expected 00/0", alloc_gnt, alloc_tags);
    end
    checks++;
    if (busy !== 1'b0 || free_count !== 7'd32 || arch_rd_idx !== '0 || double_free_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b fc=%0d idx=%h err=%b, expected 0/32/0/0",
               busy, free_count, arch_rd_idx, double_free_err);
    end
    tick;
    reset = 1'b0; alloc_req = '0;
    model_map = {{32{1'b1}}, {32{1'b0}}};
  endtask

  task automatic test_alloc_basic;
    drive(2'b11, '0);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || free_count !== e.fc) begin
      errors++; $display("[TB] FAIL basic_sb: got %b/%h/%0d, expected %b/%h/%0d",
                         alloc_gnt, alloc_tags, free_count, e.gnt, e.tags, e.fc);
    end
    checks++;
    if (alloc_tags !== {6'd32, 6'd33}) begin
      errors++; $display("[TB] FAIL basic_tags: got %h, expected tags1=32 tags0=33", alloc_tags);
    end
    tick;
    drive(2'b00, '0);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (free_count !== 7'd30 || alloc_gnt !== e.gnt) begin
      errors++; $display("[TB] FAIL basic_count: got fc=%0d gnt=%b, expected 30/00", free_count, alloc_gnt);
    end
    tick;
  endtask

  task automatic test_drain;
    logic [1:0] req;
    for (int i = 0; i < 17; i++) begin
      req = (i < 14) ? 2'b11 : (i == 14) ? 2'b10 : (i == 15) ? 2'b11 : 2'b01;
      drive(req, '0);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || free_count !== e.fc) begin
        errors++; $display("[TB] FAIL drain_sb[%0d]: got %b/%h/%0d, expected %b/%h/%0d",
                           i, alloc_gnt, alloc_tags, free_count, e.gnt, e.tags, e.fc);
      end
      if (i == 15) begin
        checks++;
        if (alloc_gnt !== 2'b10 || alloc_tags[5:0] !== 6'd0) begin
          errors++; $display("[TB] FAIL drain_last: got gnt=%b tag0=%0d, expected 10/0", alloc_gnt, alloc_tags[5:0]);
        end
      end
      tick;
    end
  endtask

  task automatic test_free;
    logic [1:0]  reqs [5];
    logic [63:0] fms  [5];
    reqs = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
    fms  = '{64'd1 << 40, 64'd0, 64'h61, 64'd0, 64'd0};
    for (int i = 0; i < 5; i++) begin
      drive(reqs[i], fms[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || free_count !== e.fc) begin
        errors++; $display("[TB] FAIL free_sb[%0d]: got %b/%h/%0d, expected %b/%h/%0d",
                           i, alloc_gnt, alloc_tags, free_count, e.gnt, e.tags, e.fc);
      end
      if (i == 1) begin
        checks++;
        if (alloc_gnt !== 2'b01 || alloc_tags[5:0] !== 6'd40) begin
          errors++; $display("[TB] FAIL free_latency: got gnt=%b tag0=%0d, expected 01/40", alloc_gnt, alloc_tags[5:0]);
        end
      end
      tick;
    end
    free_mask = '0;
  endtask

  task automatic test_recover;
    logic [SCAN_W*RIW-1:0] idx_exp;
    for (int i = 0; i < ARCH_COUNT; i++) arch_map[i] = PRW'(i + 10);
    drive(2'b00, 64'd1 << 45);
    @(negedge clock);
    e = exp_q.pop_front();
    tick;
    alloc_req = 2'b11; free_mask = 64'd1 << 7; recover_en = 1'b1;
    @(negedge clock);
    checks++;
    if (alloc_gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL recover_pulse: got gnt=%b busy=%b, expected 00/0", alloc_gnt, busy);
    end
    tick;
    recover_en = 1'b0; free_mask = 64'd1 << 20;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < SCAN_W; j++) idx_exp[j*RIW +: RIW] = RIW'(k*SCAN_W + j);
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || alloc_gnt !== 2'b00 || arch_rd_idx !== idx_exp || free_count !== 7'd2) begin
        errors++; $display("[TB] FAIL rebuild[%0d]: got busy=%b gnt=%b idx=%h fc=%0d, expected 1/00/%h/2",
                           k, busy, alloc_gnt, arch_rd_idx, free_count, idx_exp);
      end
      tick;
    end
    free_mask = '0; alloc_req = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || free_count !== 7'd31) begin
      errors++; $display("[TB] FAIL rebuild_done: got busy=%b fc=%0d, expected 0/31", busy, free_count);
    end
    model_map = '0;
    for (int p = 1; p <= 9; p++) model_map[p] = 1'b1;
    for (int p = 42; p < 64; p++) model_map[p] = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      drive(2'b11, '0);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || free_count !== e.fc) begin
        errors++; $display("[TB] FAIL post_rebuild[%0d]: got %b/%h/%0d, expected %b/%h/%0d",
                           i, alloc_gnt, alloc_tags, free_count, e.gnt, e.tags, e.fc);
      end
      tick;
    end
    alloc_req = '0;
  endtask

  task automatic test_restart_reset;
    logic [SCAN_W*RIW-1:0] idx_exp;
    int cnt;
    for (int i = 0; i < ARCH_COUNT; i++) arch_map[i] = PRW'(i + 20);
    recover_en = 1'b1;
    tick;
    recover_en = 1'b0;
    repeat (5) tick;
    recover_en = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || arch_rd_idx[RIW-1:0] !== 5'd20) begin
      errors++; $display("[TB] FAIL restart_pulse: got busy=%b idx0=%0d, expected 1/20", busy, arch_rd_idx[RIW-1:0]);
    end
    tick;
    recover_en = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      for (int j = 0; j < SCAN_W; j++) idx_exp[j*RIW +: RIW] = RIW'(cnt*SCAN_W + j);
      checks++;
      if (arch_rd_idx !== idx_exp) begin
        errors++; $display("[TB] FAIL restart_idx[%0d]: got %h, expected %h", cnt, arch_rd_idx, idx_exp);
      end
      cnt++;
      tick;
    end
    checks++;
    if (cnt != 8 || free_count !== 7'd31) begin
      errors++; $display("[TB] FAIL restart_len: got %0d busy cycles fc=%0d, expected 8/31", cnt, free_count);
    end
    tick;
    recover_en = 1'b1;
    tick;
    recover_en = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_map = {{32{1'b1}}, {32{1'b0}}};
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || free_count !== 7'd32 || arch_rd_idx !== '0) begin
      errors++; $display("[TB] FAIL mid_reset: got busy=%b fc=%0d idx=%h, expected 0/32/0", busy, free_count, arch_rd_idx);
    end
    tick;
    drive(2'b11, '0);
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || alloc_tags !== {6'd32, 6'd33}) begin
      errors++; $display("[TB] FAIL mid_reset_alloc: got %b/%h, expected %b/%h", alloc_gnt, alloc_tags, e.gnt, e.tags);
    end
    tick;
    alloc_req = '0;
  endtask

  task automatic test_double_free;
    logic err_exp;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    drive(2'b00, 64'd1 << 50);
    @(negedge clock);
    e = exp_q.pop_front();
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, '0);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (double_free_err !== err_exp || free_count !== e.fc) begin
        errors++; $display("[TB] FAIL double_free[%0d]: got err=%b fc=%0d, expected %b/%0d",
                           i, double_free_err, free_count, err_exp, e.fc);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [PHYS_REGS-1:0] fm;
    int p;
    for (int i = 0; i < 60; i++) begin
      fm = '0;
      p = $urandom_range(1, PHYS_REGS - 1);
      if (!model_map[p] && $urandom_range(0, 1) == 1) fm[p] = 1'b1;
      drive(2'($urandom_range(0, 3)), fm);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (alloc_gnt !== e.gnt || alloc_tags !== e.tags || free_count !== e.fc) begin
        errors++; $display("[TB] FAIL b2b[%0d]: got %b/%h/%0d, expected %b/%h/%0d",
                           i, alloc_gnt, alloc_tags, free_count, e.gnt, e.tags, e.fc);
      end
      tick;
    end
    alloc_req = '0; free_mask = '0;
  endtask

  initial begin
    test_reset;
    test_alloc_basic;
    test_drain;
    test_free;
    test_recover;
    test_restart_reset;
    test_double_free;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
